// File: rtl/stream_fifo_if.sv
// Handshake bundle for stream_fifo: write side, read side and occupancy status.
// The FIFO connects through the slave modport, producer/consumer through master.
interface stream_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             io_write_valid;
  logic             io_write_ready;
  logic [WIDTH-1:0] io_write_bits;
  logic             io_read_valid;
  logic             io_read_ready;
  logic [WIDTH-1:0] io_read_bits;
  logic [CW-1:0]    io_count;
  logic             io_almost_full;
  logic             io_almost_empty;

  modport slave (
    input  io_write_valid, io_write_bits, io_read_ready,
    output io_write_ready, io_read_valid, io_read_bits,
           io_count, io_almost_full, io_almost_empty
  );

  modport master (
    output io_write_valid, io_write_bits, io_read_ready,
    input  io_write_ready, io_read_valid, io_read_bits,
           io_count, io_almost_full, io_almost_empty
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with occupancy count and almost flags.
// Define STREAM_FIFO_BYPASS_EN to pass a word straight through when empty.
module stream_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic          io_clk,
  input  logic          io_rst_n,
  input  logic          io_flush,
  stream_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             empty, full;
  logic             wr_ok;
  logic             push, pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  // Readiness deliberately ignores io_read_ready: no pass-through when full.
  assign wr_ok = io_rst_n && !full && !io_flush;

`ifdef STREAM_FIFO_BYPASS_EN
  logic bypass;
  assign bypass            = empty && bus.io_write_valid && wr_ok;
  assign bus.io_read_valid = !empty || bypass;
  assign bus.io_read_bits  = empty ? bus.io_write_bits : mem[rd_ptr];
  // A word handed straight to the consumer never touches storage.
  assign push = bus.io_write_valid && wr_ok && !(bypass && bus.io_read_ready);
  assign pop  = !empty && bus.io_read_ready;
`else
  assign bus.io_read_valid = !empty;
  assign bus.io_read_bits  = mem[rd_ptr];
  assign push = bus.io_write_valid && wr_ok;
  assign pop  = !empty && bus.io_read_ready;
`endif

  assign bus.io_write_ready  = wr_ok;
  assign bus.io_count        = count;
  assign bus.io_almost_full  = (count >= AF_CNT);
  assign bus.io_almost_empty = (count <= AE_CNT);

  // Storage is left uninitialised; only pointers and count define contents.
  always_ff @(posedge io_clk) begin
    if (push) mem[wr_ptr] <= bus.io_write_bits;
  end

  always_ff @(posedge io_clk) begin
    if (!io_rst_n || io_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// Randomised + directed bench for stream_fifo against a queue reference model.
module tb_stream_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic io_clk = 1'b0;
  logic io_rst_n;
  logic io_flush;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [WIDTH-1:0] q[$];

  stream_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .io_clk  (io_clk),
    .io_rst_n(io_rst_n),
    .io_flush(io_flush),
    .bus     (bus.slave)
  );

  always #5 io_clk = ~io_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic cyc(input logic rst, input logic fl, input logic wv,
                     input logic [WIDTH-1:0] wb, input logic rr);
    int   n;
    logic ewr, bp, erv;
    io_rst_n = rst;
    io_flush = fl;
    bus.io_write_valid = wv;
    bus.io_write_bits  = wb;
    bus.io_read_ready  = rr;
    @(negedge io_clk);
    n   = q.size();
    ewr = rst && (n < DEPTH) && !fl;
    bp  = 1'b0;
`ifdef STREAM_FIFO_BYPASS_EN
    bp  = (n == 0) && wv && ewr;
`endif
    erv = (n != 0) || bp;
    chk("count",  32'(bus.io_count), 32'(n));
    chk("wready", 32'(bus.io_write_ready), 32'(ewr));
    chk("rvalid", 32'(bus.io_read_valid), 32'(erv));
    chk("afull",  32'(bus.io_almost_full), 32'(n >= DEPTH - 2));
    chk("aempty", 32'(bus.io_almost_empty), 32'(n <= 1));
    if (erv) chk("rbits", bus.io_read_bits, bp ? wb : q[0]);
    @(posedge io_clk);
    if (!rst || fl) q.delete();
    else if (!(bp && rr)) begin
      if (erv && rr) void'(q.pop_front());
      if (wv && ewr) q.push_back(wb);
    end
    #1;
  endtask

  initial begin
    io_rst_n = 1'b0;
    io_flush = 1'b0;
    bus.io_write_valid = 1'b0;
    bus.io_write_bits  = '0;
    bus.io_read_ready  = 1'b0;
    @(posedge io_clk); #1;
    q.delete();

    // reset, then fill past full
    repeat (2) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 32'(i), 0);
    chk("fill_cnt", 32'(bus.io_count), 32'd8);

    // drain in order
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 1);
    chk("drain_cnt", 32'(bus.io_count), 32'd0);

    // wrap with steady count 3
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'h100 + 32'(i), 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, $urandom, 1);
    chk("wrap_cnt", 32'(bus.io_count), 32'd3);

    // flush at count 5 with a write pending
    for (int i = 0; i < 2; i++) cyc(1, 0, 1, $urandom, 0);
    cyc(1, 1, 1, 32'hDEAD_BEEF, 0);
    cyc(1, 0, 0, 0, 0);
    chk("flush_cnt", 32'(bus.io_count), 32'd0);

    // reset mid-operation at count 4
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, $urandom, 0);
    cyc(0, 0, 1, 32'h1234_5678, 1);
    cyc(1, 0, 0, 0, 0);
    chk("rst_cnt", 32'(bus.io_count), 32'd0);

    // write into an empty FIFO with the consumer ready
    cyc(1, 0, 1, 32'hA5A5_A5A5, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("byp_cnt", 32'(bus.io_count), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 1) == 1));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per word.
REQ-002 SHALL have parameter DEPTH, default 8, storage words; power of two, >= 2.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost-full occupancy threshold.
REQ-004 SHALL have parameter AEMPTY_TH, default 1, almost-empty occupancy threshold.
REQ-005 SHALL have port io_clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port io_rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port io_flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port io_write_valid  input  1  producer word present.
REQ-009 SHALL have port io_write_ready  output  1  FIFO can accept a word.
REQ-010 SHALL have port io_write_bits  input  WIDTH  write data.
REQ-011 SHALL have port io_read_valid  output  1  word available at head.
REQ-012 SHALL have port io_read_ready  input  1  consumer takes head word.
REQ-013 SHALL have port io_read_bits  output  WIDTH  head word data.
REQ-014 SHALL have port io_count  output  clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have port io_almost_full  output  1  io_count >= AFULL_TH.
REQ-016 SHALL have port io_almost_empty  output  1  io_count <= AEMPTY_TH.

Function
REQ-017 SHALL accept a write on a rising edge where io_write_valid && io_write_ready, storing io_write_bits at the write pointer.
REQ-018 SHALL complete a read on a rising edge where io_read_valid && io_read_ready, advancing the read pointer.
REQ-019 SHALL present the head word first-word-fall-through: io_read_bits driven from storage at the read pointer, io_read_valid = (io_count != 0).
REQ-020 SHALL have write-to-read latency of 1 cycle: word accepted at edge N is visible with io_read_valid high after edge N.
REQ-021 SHALL drive io_write_ready = (io_count != DEPTH) && !io_flush; combinationally independent of io_read_ready (no full-state pass-through).
REQ-022 SHALL use log2(DEPTH)-bit read/write pointers wrapping from DEPTH-1 to 0 without gaps.
REQ-023 SHALL update io_count by +1 on write only, -1 on read only, unchanged on simultaneous read and write.
REQ-024 SHALL, on io_flush high at an edge, set pointers and io_count to 0 and discard any same-cycle read or write; stored data need not be cleared.
REQ-025 SHALL hold io_read_bits stable while io_read_valid high and io_read_ready low.
REQ-026 SHALL register no outputs beyond pointers/count; flags are combinational from io_count.

Reset
REQ-027 SHALL, on an edge with io_rst_n low, zero pointers and io_count regardless of other inputs, including mid-transfer.
REQ-028 SHALL drive during and after reset until first write: io_write_ready 0 while io_rst_n low then 1, io_read_valid 0, io_count 0, io_almost_full 0, io_almost_empty 1; io_read_bits undefined.

Configuration
REQ-029 SHALL support macro STREAM_FIFO_BYPASS_EN.
REQ-030 SHALL, with STREAM_FIFO_BYPASS_EN defined and io_count == 0, drive io_read_valid = io_write_valid and io_read_bits = io_write_bits in the same cycle; if io_read_ready also high, the word is consumed without being stored and io_count stays 0.
REQ-031 SHALL, without STREAM_FIFO_BYPASS_EN, behave strictly per REQ-019/REQ-020 (no combinational write-to-read path).

Verification
REQ-032 SHALL cover fill: reset, write 8 words 0x0..0x7 with io_read_ready=0 -> io_count=8, io_write_ready=0, io_almost_full=1 from count 6; 9th write not accepted.
REQ-033 SHALL cover drain/order: after fill, io_read_ready=1 for 8 cycles -> reads 0x0..0x7 in order, then io_read_valid=0, io_almost_empty=1 at count<=1.
REQ-034 SHALL cover wrap: 20 cycles of simultaneous write and read starting from count 3 -> io_count stays 3, data order preserved across pointer wrap.
REQ-035 SHALL cover flush: count 5, assert io_flush with io_write_valid=1 -> next cycle io_count=0, io_read_valid=0, flushed-cycle write lost.
REQ-036 SHALL cover reset mid-operation: count 4, io_rst_n low one cycle with read and write active -> io_count=0, io_write_ready=0 during reset, 1 after.
REQ-037 SHALL cover bypass: empty FIFO, write 0xA5A5A5A5 with io_read_ready=1 -> with STREAM_FIFO_BYPASS_EN same-cycle read, io_count 0; without it read_valid one cycle later, io_count 1 then 0.
